mem_xfer_arbiter: RTL

- Parametrised successor of the single-channel memory controller. Owns the shared processor–memory bus for N_CH processor channels.
- Round-robin arbitrates processor write ownership through one-hot grant lines.
- Queues memory "done" events with their destination channel in a small FIFO. Runs each read-return as a counted burst of BURST_LEN beats, pulsing pop at burst start and recieved at completion.
- Optionally lets writes suspend and later resume a read burst.

---
 rtl/mem_xfer_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_xfer_arbiter.sv
// Shared processor/memory bus owner for N_CH channels: round-robin write grants,
// a done-event FIFO and counted read-return bursts that writes may suspend.
module mem_xfer_arbiter #(
    parameter int N_CH       = 4,
    parameter int BURST_LEN  = 10,
    parameter int DONE_DEPTH = 4,
    parameter int PREEMPT    = 1,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int CNT_W      = $clog2(BURST_LEN + 1),
    parameter int PW         = $clog2(DONE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  send_req,
    input  logic             done,
    input  logic [CH_W-1:0]  done_id,
    output logic [N_CH-1:0]  grant_line,
    output logic             bus_free,
    output logic [N_CH-1:0]  iamtaking,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             pop,
    output logic [N_CH-1:0]  recieved,
    output logic [PW-1:0]    pend_cnt,
    output logic             overflow
);

    localparam int AW = $clog2(DONE_DEPTH);
    localparam bit PREEMPT_EN = (PREEMPT != 0);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_READ = 2'd2} state_t;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        return {{(N_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // First requester at or after ptr, wrapping around the channel list.
    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req, input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr) + i) % N_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
        return sel;
    endfunction

    state_t            state_r, state_n;
    logic [N_CH-1:0]   grant_r, grant_n;
    logic [N_CH-1:0]   take_r, take_n;
    logic [CNT_W-1:0]  beat_r, beat_n;
    logic              pop_r, pop_n;
    logic [N_CH-1:0]   recv_r, recv_n;
    logic              bus_free_r;
    logic [CH_W-1:0]   owner_r, owner_n;
    logic [CH_W-1:0]   rr_r, rr_n;
    logic [CH_W-1:0]   cur_r, cur_n;
    logic              susp_r, susp_n;
    logic              ovf_r;

    logic [CH_W-1:0]   fifo_mem_r [DONE_DEPTH];
    logic [AW-1:0]     rd_ptr_r, wr_ptr_r;
    logic [PW-1:0]     count_r;

    logic              req_any_s, owner_drop_s, last_beat_s;
    logic              fifo_empty_s, fifo_full_s, fifo_pop_s, fifo_push_s, fifo_drop_s;
    logic [CH_W-1:0]   pick_s, head_s, owner_inc_s;

    assign req_any_s    = |send_req;
    assign owner_drop_s = ~send_req[owner_r];
    assign last_beat_s  = (beat_r == LAST_BEAT);
    assign pick_s       = rr_pick(send_req, rr_r);
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign owner_inc_s  = (owner_r == CH_W'(N_CH - 1)) ? CH_W'(0) : owner_r + CH_W'(1);
    assign fifo_empty_s = (count_r == PW'(0));
    assign fifo_full_s  = (count_r == PW'(DONE_DEPTH));
    // A pop at the same edge frees the slot a full-FIFO push needs.
    assign fifo_push_s  = done & (~fifo_full_s | fifo_pop_s);
    assign fifo_drop_s  = done & fifo_full_s & ~fifo_pop_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state selection; writes win over a pending read start.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_n = ST_WRITE;
                end else if (!fifo_empty_s) begin
                    state_n = ST_READ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (owner_drop_s) begin
                    state_n = susp_r ? ST_READ : ST_IDLE;
                end else begin
                    state_n = ST_WRITE;
                end
            end
            ST_READ: begin
                if (last_beat_s) begin
                    state_n = ST_IDLE;
                end else if (PREEMPT_EN && req_any_s) begin
                    state_n = ST_WRITE;
                end else begin
                    state_n = ST_READ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping state.
    always_comb begin
        grant_n    = '0;
        take_n     = '0;
        beat_n     = beat_r;
        pop_n      = 1'b0;
        recv_n     = '0;
        owner_n    = owner_r;
        rr_n       = rr_r;
        cur_n      = cur_r;
        susp_n     = susp_r;
        fifo_pop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                beat_n = '0;
                if (req_any_s) begin
                    owner_n = pick_s;
                    grant_n = onehot(pick_s);
                end else if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    cur_n      = head_s;
                    beat_n     = CNT_W'(1);
                    take_n     = onehot(head_s);
                    pop_n      = 1'b1;
                end else begin
                    beat_n = '0;
                end
            end
            ST_WRITE: begin
                if (owner_drop_s) begin
                    rr_n = owner_inc_s;
                    if (susp_r) begin
                        susp_n = 1'b0;
                        beat_n = beat_r + CNT_W'(1);
                        take_n = onehot(cur_r);
                    end else begin
                        beat_n = '0;
                    end
                end else begin
                    grant_n = grant_r;
                end
            end
            ST_READ: begin
                if (last_beat_s) begin
                    beat_n = '0;
                    recv_n = onehot(cur_r);
                end else if (PREEMPT_EN && req_any_s) begin
                    susp_n  = 1'b1;
                    owner_n = pick_s;
                    grant_n = onehot(pick_s);
                end else begin
                    beat_n = beat_r + CNT_W'(1);
                    take_n = onehot(cur_r);
                end
            end
            default: beat_n = '0;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r    <= '0;
            take_r     <= '0;
            beat_r     <= '0;
            pop_r      <= 1'b0;
            recv_r     <= '0;
            bus_free_r <= 1'b1;
            owner_r    <= '0;
            rr_r       <= '0;
            cur_r      <= '0;
            susp_r     <= 1'b0;
        end else begin
            grant_r    <= grant_n;
            take_r     <= take_n;
            beat_r     <= beat_n;
            pop_r      <= pop_n;
            recv_r     <= recv_n;
            bus_free_r <= (state_n == ST_IDLE);
            owner_r    <= owner_n;
            rr_r       <= rr_n;
            cur_r      <= cur_n;
            susp_r     <= susp_n;
        end
    end

    // Done-event FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (fifo_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (fifo_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   count_r <= count_r + PW'(1);
                2'b01:   count_r <= count_r - PW'(1);
                default: count_r <= count_r;
            endcase
            if (fifo_drop_s) ovf_r <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (fifo_push_s) fifo_mem_r[wr_ptr_r] <= done_id;
    end

    assign grant_line = grant_r;
    assign bus_free   = bus_free_r;
    assign iamtaking  = take_r;
    assign beat_cnt   = beat_r;
    assign pop        = pop_r;
    assign recieved   = recv_r;
    assign pend_cnt   = count_r;
    assign overflow   = ovf_r;

endmodule
